serial_adder: RTL and testbench

//  Bit-serial ripple adder. Adds two WIDTH-bit operands LSB-first, one bit per clock,

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single
// one-bit add cell and a carry flip-flop. A start/done handshake frames each
// operation: IDLE -> SHIFT (WIDTH cycles) -> DONE (one cycle) -> IDLE.
// Sum/Carry are registered and change only when DONE is entered or on reset.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    // The bit counter only needs to reach WIDTH-1; keep at least one bit so
    // the WIDTH=1 case still has a legal vector.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] acc_d;

    // One-bit add cell: sum bit, next carry and the accumulator with the new
    // sum bit shifted in at the MSB.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no
        // latch can be inferred.
        s_d   = sh_a_q[0] ^ sh_b_q[0] ^ c_q;
        c_d   = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & c_q) | (sh_b_q[0] & c_q);
        acc_d = (acc_q >> 1) | (WIDTH'(s_d) << (WIDTH - 1));
    end

    // Control FSM and datapath registers. The result is latched from the
    // next-state accumulator/carry on the edge that enters DONE, so the final
    // bit is included without an extra cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, like real flip-flops.
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_a_q  <= A;
                        sh_b_q  <= B;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    c_q    <= c_d;
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= acc_d;
                        carry_q <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign Sum   = sum_q;
    assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder at WIDTH = 8, 13 and 1.
// Expected results come from plain integer addition; expected timing comes
// from the handshake rules (done exactly WIDTH edges after the accepting edge,
// one result every WIDTH+2 cycles with start held high).

module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic        rst8,  start8,  busy8,  done8,  carry8;
    logic [7:0]  a8, b8, sum8;
    logic        rst13, start13, busy13, done13, carry13;
    logic [12:0] a13, b13, sum13;
    logic        rst1,  start1,  busy1,  done1,  carry1;
    logic [0:0]  a1, b1, sum1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
    );

    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst13), .start(start13), .A(a13), .B(b13),
        .busy(busy13), .done(done13), .Sum(sum13), .Carry(carry13)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Sum(sum1), .Carry(carry1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; observe/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (w)
            8:  begin start8  = s; a8  = a[7:0];  b8  = b[7:0];  end
            13: begin start13 = s; a13 = a[12:0]; b13 = b[12:0]; end
            default: begin start1 = s; a1 = a[0:0]; b1 = b[0:0]; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            8:       return done8;
            13:      return done13;
            default: return done1;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:       return busy8;
            13:      return busy13;
            default: return busy1;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int w);
        case (w)
            8:       return 32'(sum8);
            13:      return 32'(sum13);
            default: return 32'(sum1);
        endcase
    endfunction

    function automatic logic [31:0] get_carry(input int w);
        case (w)
            8:       return 32'(carry8);
            13:      return 32'(carry13);
            default: return 32'(carry1);
        endcase
    endfunction

    // Reference model: plain (A+B) split into low w bits and bit w.
    function automatic logic [31:0] ref_full(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (32'(a) & mask) + (32'(b) & mask);
    endfunction

    // One complete operation: start pulse, operands scrambled right after
    // acceptance, then timing and result checks against the model.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] prev_sum, full;
        int          n, busy_n;
        bit          moved;
        n        = 0;
        busy_n   = 0;
        moved    = 1'b0;
        full     = ref_full(w, a, b);
        prev_sum = get_sum(w);
        drive(w, 1'b1, a, b);
        tick();
        drive(w, 1'b0, 16'($urandom), 16'($urandom));
        while (!get_done(w) && n < 100) begin
            if (get_busy(w)) busy_n++;
            if (get_sum(w) !== prev_sum) moved = 1'b1;
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(w));
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(w));
        check({tag, ".sum_stable"}, 32'(moved), 32'd0);
        check({tag, ".sum"}, get_sum(w), full & ((32'd1 << w) - 32'd1));
        check({tag, ".carry"}, get_carry(w), (full >> w) & 32'd1);
        check({tag, ".busy_at_done"}, 32'(get_busy(w)), 32'd0);
        tick();
        check({tag, ".done_one_cycle"}, 32'(get_done(w)), 32'd0);
    endtask

    initial begin
        int n_done, first_done, last_done;
        logic [31:0] sum_at_done;

        rst8 = 1'b1; rst13 = 1'b1; rst1 = 1'b1;
        drive(8, 1'b1, 16'hFFFF, 16'hFFFF);
        drive(13, 1'b1, 16'hFFFF, 16'hFFFF);
        drive(1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick();
        tick();
        // Reset wins over a simultaneous start.
        check("reset.busy8", 32'(busy8), 32'd0);
        check("reset.done8", 32'(done8), 32'd0);
        check("reset.sum8", 32'(sum8), 32'd0);
        check("reset.carry8", 32'(carry8), 32'd0);
        check("reset.sum13", 32'(sum13), 32'd0);
        check("reset.busy1", 32'(busy1), 32'd0);
        drive(8, 1'b0, 16'h0, 16'h0);
        drive(13, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 16'h0, 16'h0);
        rst8 = 1'b0; rst13 = 1'b0; rst1 = 1'b0;
        tick();

        // Directed operands including overflow cases.
        run_op(8, 16'h0F, 16'h01, "t1_0f_01");
        run_op(8, 16'hFF, 16'h01, "t2_ff_01");
        run_op(8, 16'hFF, 16'hFF, "t2_ff_ff");

        // start pulse plus operand change in the middle of SHIFT.
        drive(8, 1'b1, 16'h03, 16'h04);
        tick();
        drive(8, 1'b0, 16'h03, 16'h04);
        n_done = 0; first_done = -1; sum_at_done = '0;
        for (int n = 0; n < 20; n++) begin
            if (n == 2) drive(8, 1'b1, 16'h55, 16'hAA);
            if (n == 4) drive(8, 1'b0, 16'h55, 16'hAA);
            if (done8) begin
                n_done++;
                if (first_done < 0) begin
                    first_done  = n;
                    sum_at_done = {23'd0, carry8, sum8};
                end
            end
            tick();
        end
        check("t3.done_count", 32'(n_done), 32'd1);
        check("t3.done_time", 32'(first_done), 32'd8);
        check("t3.result", sum_at_done, 32'h007);

        // Reset during the 4th SHIFT cycle aborts the operation.
        drive(8, 1'b1, 16'h33, 16'h11);
        tick();
        drive(8, 1'b0, 16'h33, 16'h11);
        tick(); tick(); tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("t4.busy", 32'(busy8), 32'd0);
        check("t4.done", 32'(done8), 32'd0);
        check("t4.sum", 32'(sum8), 32'd0);
        check("t4.carry", 32'(carry8), 32'd0);
        n_done = 0;
        for (int n = 0; n < 12; n++) begin
            if (done8 || busy8) n_done++;
            tick();
        end
        check("t4.no_activity", 32'(n_done), 32'd0);
        run_op(8, 16'h20, 16'h22, "t4_20_22");

        // start held high: a result every WIDTH+2 cycles.
        drive(8, 1'b1, 16'h01, 16'h01);
        tick();
        n_done = 0; first_done = -1; last_done = -1;
        for (int n = 0; n < 32; n++) begin
            if (done8) begin
                check("t5.sum", 32'(sum8), 32'h02);
                if (last_done >= 0) check("t5.period", 32'(n - last_done), 32'd10);
                if (first_done < 0) first_done = n;
                last_done = n;
                n_done++;
            end
            tick();
        end
        drive(8, 1'b0, 16'h01, 16'h01);
        check("t5.done_count", 32'(n_done), 32'd3);
        check("t5.first_done", 32'(first_done), 32'd8);
        for (int n = 0; n < 12; n++) tick();

        // WIDTH=1 corner.
        run_op(1, 16'h1, 16'h1, "t6_w1_1_1");
        for (int i = 0; i < 20; i++) run_op(1, 16'($urandom), 16'($urandom), "rand_w1");

        // Randomised comparison against plain addition.
        for (int i = 0; i < 1000; i++) run_op(8, 16'($urandom), 16'($urandom), "rand_w8");
        for (int i = 0; i < 1000; i++) run_op(13, 16'($urandom), 16'($urandom), "rand_w13");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
